// File: rtl/pcm_sample_buffer.sv
// WAV byte stream to PCM sample FIFO feeding audio_drive.
// Skips the header, packs little-endian byte pairs and serves one sample per req.
module pcm_sample_buffer #(
    parameter int unsigned DEPTH         = 512,
    parameter int unsigned AW            = 9,
    parameter int unsigned HDR_BYTES     = 44,
    parameter logic [15:0] UNDERRUN_FILL = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic          req,
    output logic [15:0]   idata,
    output logic [AW:0]   level,
    output logic          empty,
    output logic [15:0]   underrun_cnt
);

    typedef enum logic [1:0] {IDLE, SKIP, LO, HI} state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [15:0] HDR_LD   = 16'(HDR_BYTES);

    state_t        state;
    logic [15:0]   mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    lo_byte;
    logic [15:0]   skip_cnt;
    logic          full;
    logic          accept;
    logic          wr_en;
    logic          rd_en;
    logic          under;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    always_comb begin
        byte_ready = 1'b0;
        case (state)
            SKIP, LO: byte_ready = 1'b1;
            HI:       byte_ready = ~full;
            default:  byte_ready = 1'b0;
        endcase
    end

    // start and stop both take priority over a byte offered in the same cycle
    assign accept = byte_valid & byte_ready & ~start & ~stop;
    assign wr_en  = accept & (state == HI);
    assign rd_en  = req & ~start & ~empty;
    assign under  = req & (start | empty);

    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            mem[wr_ptr] <= {byte_data, lo_byte};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            idata        <= '0;
            underrun_cnt <= '0;
            lo_byte      <= '0;
            skip_cnt     <= '0;
        end else begin
            if (rd_en) begin
                idata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end else if (under) begin
                idata <= UNDERRUN_FILL;
                if (underrun_cnt != '1)
                    underrun_cnt <= underrun_cnt + 1'b1;
            end

            if (start) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                lo_byte  <= '0;
                skip_cnt <= HDR_LD;
                state    <= (HDR_BYTES > 0) ? SKIP : LO;
            end else begin
                case ({wr_en, rd_en})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
                if (wr_en)
                    wr_ptr <= wr_ptr + 1'b1;

                if (stop) begin
                    state <= IDLE;
                end else if (accept) begin
                    case (state)
                        SKIP: begin
                            skip_cnt <= skip_cnt - 1'b1;
                            if (skip_cnt == 16'd1)
                                state <= LO;
                        end
                        LO: begin
                            lo_byte <= byte_data;
                            state   <= HI;
                        end
                        HI:      state <= LO;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Bench for pcm_sample_buffer: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the byte stream and sample FIFO.
module tb_pcm_sample_buffer;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;
    localparam int unsigned HDR   = 44;
    localparam logic [15:0] FILL  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, byte_valid, req;
    logic [7:0]  byte_data;
    logic        byte_ready, empty;
    logic [15:0] idata, underrun_cnt;
    logic [AW:0] level;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // reference model: stream position and a plain sample queue
    logic [15:0] q[$];
    bit          active;
    bit          have_lo;
    logic [7:0]  lo_b;
    int unsigned hdr_left;
    logic [15:0] m_idata;
    int unsigned m_ucnt;
    logic [7:0]  bcnt = 8'h00;

    pcm_sample_buffer #(
        .DEPTH(DEPTH), .AW(AW), .HDR_BYTES(HDR), .UNDERRUN_FILL(FILL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .req(req), .idata(idata), .level(level), .empty(empty),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return active && (hdr_left > 0 || !have_lo || q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        q.delete();
        active   = 1'b0;
        have_lo  = 1'b0;
        lo_b     = 8'h00;
        hdr_left = 0;
        m_idata  = 16'h0000;
        m_ucnt   = 0;
    endtask

    task automatic step(input bit st, input bit sp, input bit bv,
                        input logic [7:0] bd, input bit rq, input bit rn);
        bit exp_br;
        bit acc;
        int unsigned pre;
        @(negedge clk);
        start = st; stop = sp; byte_valid = bv; byte_data = bd; req = rq; rst_n = rn;
        #1;
        exp_br = model_ready();
        chk("byte_ready", 32'(byte_ready), 32'(exp_br));
        acc = bv && exp_br && !st && !sp;
        pre = q.size();
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            if (rq) begin
                if (st || pre == 0) begin
                    m_idata = FILL;
                    if (m_ucnt < 65535) m_ucnt++;
                end else begin
                    m_idata = q.pop_front();
                end
            end
            if (st) begin
                q.delete();
                active   = 1'b1;
                hdr_left = HDR;
                have_lo  = 1'b0;
            end else if (sp) begin
                active  = 1'b0;
                have_lo = 1'b0;
            end else if (acc) begin
                if (hdr_left > 0) hdr_left--;
                else if (!have_lo) begin lo_b = bd; have_lo = 1'b1; end
                else begin q.push_back({bd, lo_b}); have_lo = 1'b0; end
            end
        end
        #1;
        chk("level", 32'(level), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("idata", 32'(idata), 32'(m_idata));
        chk("underrun_cnt", 32'(underrun_cnt), m_ucnt);
    endtask

    task automatic feed(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step(0, 0, 1, bcnt, 0, 1);
            bcnt = bcnt + 8'd1;
        end
    endtask

    task automatic byte1(input logic [7:0] b);
        step(0, 0, 1, b, 0, 1);
    endtask

    initial begin
        model_reset();
        start = 0; stop = 0; byte_valid = 0; byte_data = 0; req = 0; rst_n = 0;
        step(0, 0, 0, 8'h00, 0, 0);
        step(0, 0, 0, 8'h00, 0, 0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(byte_ready), 32'd0);

        // T1: header skip and little-endian packing
        step(1, 0, 0, 8'h00, 0, 1);
        feed(HDR);
        byte1(8'h34); byte1(8'h12); byte1(8'hCD); byte1(8'hAB);
        step(0, 0, 0, 8'h00, 1, 1);
        chk("t1_first", 32'(idata), 32'h1234);
        step(0, 0, 0, 8'h00, 1, 1);
        chk("t1_second", 32'(idata), 32'hABCD);
        chk("t1_ucnt", 32'(underrun_cnt), 32'd0);

        // T3: underruns, including a req in the same cycle as the completing byte
        step(0, 0, 1, 8'h55, 1, 1);
        chk("t3_u1", 32'(idata), 32'(FILL));
        step(0, 0, 0, 8'h00, 1, 1);
        chk("t3_u2", 32'(idata), 32'(FILL));
        step(0, 0, 1, 8'h66, 1, 1);
        chk("t3_u3", 32'(idata), 32'(FILL));
        chk("t3_ucnt", 32'(underrun_cnt), 32'd3);
        step(0, 0, 0, 8'h00, 1, 1);
        chk("t3_late", 32'(idata), 32'h6655);

        // T2: fill to DEPTH, back-pressure in HI, one read frees one slot
        step(1, 0, 0, 8'h00, 0, 1);
        feed(HDR + 2 * DEPTH + 10);
        chk("t2_full", 32'(level), 32'(DEPTH));
        chk("t2_bp", 32'(byte_ready), 32'd0);
        step(0, 0, 1, 8'h77, 1, 1);
        chk("t2_read", 32'(level), 32'(DEPTH - 1));
        byte1(8'h78);
        chk("t2_refill", 32'(level), 32'(DEPTH));

        // T4: start + req mid-stream flushes and restarts the header skip
        step(1, 0, 0, 8'h00, 0, 1);
        feed(HDR + 201);
        chk("t4_lvl", 32'(level), 32'd100);
        step(1, 0, 1, 8'h99, 1, 1);
        chk("t4_flush", 32'(level), 32'd0);
        chk("t4_fill", 32'(idata), 32'(FILL));
        feed(HDR + 2);
        chk("t4_skip", 32'(level), 32'd1);

        // T5: stop with a pending low byte; stored samples still drain
        step(1, 0, 0, 8'h00, 0, 1);
        feed(HDR + 21);
        step(0, 1, 0, 8'h00, 0, 1);
        chk("t5_idle", 32'(byte_ready), 32'd0);
        feed(3);
        chk("t5_hold", 32'(level), 32'd10);
        for (int i = 0; i < 11; i++) step(0, 0, 0, 8'h00, 1, 1);
        chk("t5_tail", 32'(idata), 32'(FILL));
        chk("t5_empty", 32'(empty), 32'd1);

        // randomized traffic with fill-heavy, balanced and drain-heavy phases
        step(1, 0, 0, 8'h00, 0, 1);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3000; i++) begin
                step($urandom_range(599) == 0, $urandom_range(799) == 0,
                     $urandom_range(99) < (p == 0 ? 90 : (p == 1 ? 60 : 20)),
                     8'($urandom),
                     $urandom_range(99) < (p == 0 ? 20 : (p == 1 ? 30 : 70)),
                     $urandom_range(3999) != 0);
                if (!active && $urandom_range(99) == 0) step(1, 0, 0, 8'h00, 0, 1);
            end
        end

        // T6: reset mid-stream clears everything including underrun_cnt
        step(0, 0, 0, 8'h00, 0, 0);
        step(1, 0, 0, 8'h00, 0, 1);
        step(0, 0, 0, 8'h00, 1, 1);
        feed(HDR + 75);
        chk("t6_lvl", 32'(level), 32'd37);
        step(0, 0, 0, 8'h00, 0, 0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_idata", 32'(idata), 32'd0);
        chk("t6_ucnt", 32'(underrun_cnt), 32'd0);
        chk("t6_ready", 32'(byte_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
